// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, redirect from execute,
// and the decode-facing head-of-queue handshake with occupancy.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic          imem_req;
    logic [31:0]   imem_rdata;
    logic          imem_ready;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          ins_valid;
    logic [31:0]   ins;
    logic [31:0]   ins_pc;
    logic          ins_ready;
    logic [CW-1:0] count;

    modport master (
        output imem_addr, imem_req, ins_valid, ins, ins_pc, count,
        input  imem_rdata, imem_ready, redirect, redirect_pc, ins_ready
    );

    modport slave (
        input  imem_addr, imem_req, ins_valid, ins, ins_pc, count,
        output imem_rdata, imem_ready, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC fetch from a combinational memory into a
// DEPTH-entry FIFO, with redirect flush and synchronous active-high reset.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          pop;
    logic          req;
    logic          push;

    // A pop frees a slot in the same cycle, so a full queue can still fetch.
    always_comb begin
        pop  = (count != '0) & bus.ins_ready;
        req  = ~reset & ~bus.redirect & ((count != FULL_COUNT) | pop);
        push = req & bus.imem_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
        end
    end

    // push is already gated off by reset and redirect
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[tail] <= bus.imem_rdata;
            pc_mem[tail]  <= fetch_pc;
        end
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.imem_req  = req;
    assign bus.ins_valid = (count != '0);
    assign bus.ins       = ins_mem[head];
    assign bus.ins_pc    = pc_mem[head];
    assign bus.count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a queue-based model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h0001_3579;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Reference model: fetch PC plus a queue of {pc, word} entries.
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];

    function automatic logic exp_req();
        int sz;
        sz = q_pc.size();
        return !reset && !bus.redirect && (sz < DEPTH || (sz != 0 && bus.ins_ready));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req()));
        chk("ins_valid", 32'(bus.ins_valid), 32'(q_pc.size() != 0));
        chk("count", 32'(bus.count), 32'(q_pc.size()));
        if (q_pc.size() != 0) begin
            chk("ins_pc", bus.ins_pc, q_pc[0]);
            chk("ins", bus.ins, q_ins[0]);
        end
    endtask

    task automatic model_update();
        logic do_pop;
        logic do_push;
        if (reset) begin
            m_pc = RESET_PC;
            q_pc.delete();
            q_ins.delete();
        end else if (bus.redirect) begin
            m_pc = {bus.redirect_pc[31:2], 2'b00};
            q_pc.delete();
            q_ins.delete();
        end else begin
            do_pop  = (q_pc.size() != 0) && bus.ins_ready;
            do_push = exp_req() && bus.imem_ready;
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(m_pc);
                q_ins.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Inputs are set by the caller before tick; outputs compared at the falling edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic rst, input logic rdy, input logic irdy,
                          input logic rdr, input logic [31:0] rpc);
        reset           = rst;
        bus.imem_ready  = rdy;
        bus.ins_ready   = irdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_pc   = RESET_PC;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        model_update();
        #1;
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.ins_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);

        // Streaming: one fetch per cycle, decode sees it one cycle later.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1 chk("stream_addr0", bus.imem_addr, 32'h0);
        tick();
        chk("stream_addr1", bus.imem_addr, 32'h4);
        chk("stream_pc0", bus.ins_pc, 32'h0);
        tick();
        chk("stream_addr2", bus.imem_addr, 32'h8);
        chk("stream_pc1", bus.ins_pc, 32'h4);

        // Saturation at DEPTH, then pop-and-fetch in the same cycle.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_req", 32'(bus.imem_req), 32'd0);
        chk("full_addr", bus.imem_addr, 32'h10);
        bus.ins_ready = 1'b1;
        #1 chk("full_pop_req", 32'(bus.imem_req), 32'd1);
        tick();
        chk("full_pop_count", 32'(bus.count), 32'd4);
        chk("full_pop_head", bus.ins_pc, 32'h4);
        chk("full_pop_addr", bus.imem_addr, 32'h14);

        // Redirect from a full queue, target aligned down.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        #1 chk("rdr_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("rdr_count", 32'(bus.count), 32'd0);
        chk("rdr_valid", 32'(bus.ins_valid), 32'd0);
        chk("rdr_addr", bus.imem_addr, 32'h200);
        bus.redirect = 1'b0;
        tick();
        chk("rdr_head", bus.ins_pc, 32'h200);
        chk("rdr_ins", bus.ins, mem_word(32'h200));

        // PC wrap-around at the top of the address space.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        bus.redirect  = 1'b0;
        bus.ins_ready = 1'b0;
        repeat (3) tick();
        chk("wrap_pc0", bus.ins_pc, 32'hFFFF_FFF8);
        bus.ins_ready = 1'b1;
        tick();
        chk("wrap_pc1", bus.ins_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", bus.ins_pc, 32'h0000_0000);

        // Memory stall in the middle of a stream.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        bus.imem_ready = 1'b0;
        tick();
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        #1;
        chk("stall_count", 32'(bus.count), 32'd1);
        chk("stall_head", bus.ins_pc, 32'h1004);
        chk("stall_addr", bus.imem_addr, 32'h1008);

        // Reset beats a simultaneous redirect with entries queued.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
        tick();
        bus.redirect = 1'b0;
        repeat (3) tick();
        chk("prerst_count", 32'(bus.count), 32'd3);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0800);
        tick();
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_addr", bus.imem_addr, RESET_PC);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("midrst_head", bus.ins_pc, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(99, 0) < 1,
                   $urandom_range(99, 0) < 70,
                   $urandom_range(99, 0) < 55,
                   $urandom_range(99, 0) < 4,
                   $urandom());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
